openram_bist_sequencer: RTL and testbench

On-chip march-test sequencer for the OpenRAM test macros. It takes over the SRAM select/control/address/data fields that logic-analyzer software normally drives, runs a March C- style sequence on the selected macro, and checks every read word. It reports pass/fail plus first-failure details back to the management SoC through LA/wishbone-visible registers. It sits beside the SRAM packet mux and owns the macro pins only while `busy` is high.

---
 rtl/openram_bist_pkg.sv | 45 ++++
 rtl/openram_bist_addr_gen.sv | 36 +++
 rtl/openram_bist_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_openram_bist_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/openram_bist_pkg.sv
// Shared types and constants for the OpenRAM march-test sequencer.
// Holds the march element / access phase / top state enums, the default
// background pattern, macro-select codes, and helpers describing the
// March C- operation table (which op reads, which op ends a word, and
// whether the op's data word is the "1" background).
package openram_bist_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned ERR_W  = 16;

    localparam logic [DATA_W-1:0] DEFAULT_PATTERN = 32'h5555_AAAA;

    localparam logic [SEL_W-1:0] SRAM0 = 3'd0;
    localparam logic [SEL_W-1:0] SRAM1 = 3'd1;
    localparam logic [SEL_W-1:0] SRAM2 = 3'd2;
    localparam logic [SEL_W-1:0] SRAM3 = 3'd3;
    localparam logic [SEL_W-1:0] SRAM4 = 3'd4;
    localparam logic [SEL_W-1:0] SRAM5 = 3'd5;

    typedef enum logic [1:0] {EL_M0, EL_M1, EL_M2, EL_M3} elem_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    // First op of M1..M3 is a read; M0 only writes, second ops are writes.
    function automatic logic op_is_read(elem_t e, logic op);
        return (e != EL_M0) && !op;
    endfunction

    // M0 and M3 have one op per word, M1 and M2 have two.
    function automatic logic op_is_last(elem_t e, logic op);
        return ((e == EL_M0) || (e == EL_M3)) ? 1'b1 : op;
    endfunction

    // 1 when the op uses the inverted background (w1 in M1, r1 in M2).
    function automatic logic op_data_one(elem_t e, logic op);
        case (e)
            EL_M1:   return op;
            EL_M2:   return !op;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/openram_bist_addr_gen.sv
// bist_addr_gen: loadable up/down address counter for march elements.
// load/load_up pick the element direction (up starts at 0, down at limit);
// step advances one word; term_c flags the element's last address
// (limit when counting up, 0 when counting down).
// Ports: clk, reset (sync, active high), load, load_up, step, limit,
//        addr (registered), term_c (combinational).
module bist_addr_gen #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_up,
    input  logic              step,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] addr,
    output logic              term_c
);

    logic up;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            up   <= 1'b1;
        end else if (load) begin
            up   <= load_up;
            addr <= load_up ? '0 : limit;
        end else if (step) begin
            addr <= up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
        end
    end

    assign term_c = up ? (addr == limit) : (addr == '0);

endmodule

// File: rtl/openram_bist_sequencer.sv
// openram_bist_sequencer: March C- sequencer for the OpenRAM test macros.
// Runs M0 up(w0), M1 up(r0,w1), M2 down(r1,w0), M3 up(r0) over
// 0..last_addr of the macro selected at start, checking each read word.
// Each access is SETUP -> PULSE -> WAIT x READ_LAT (reads only).
// Ports: clk, reset (sync, active high), start, abort, sram_sel_in,
//        last_addr; macro pins sram_sel/clk/csb/web/wmask/addr/din and
//        sram_dout; status busy, done, pass, fail_addr/data/elem.
// Build option BIST_ERR_COUNT_EN: adds err_count and runs to completion
// on mismatches; otherwise the run ends at the first mismatch.
module openram_bist_sequencer
    import openram_bist_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 8,
    parameter int unsigned      READ_LAT = 1,
    parameter logic [DATA_W-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sram_sel_in,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [SEL_W-1:0]  sram_sel,
    output logic              sram_clk,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [1:0]        fail_elem
`ifdef BIST_ERR_COUNT_EN
    ,
    output logic [ERR_W-1:0]  err_count
`endif
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t            state;
    elem_t             elem;
    phase_t            phase;
    logic              op;
    logic [1:0]        wait_cnt;
    logic              mism;
    logic [ADDR_W-1:0] lim;

    logic              term_c;
    logic              rd_c, last_c, cmp_c, acc_end_c, mis_c, stop_c, fin_c, start_c;
    logic              gen_load_c, gen_load_up_c, gen_step_c;
    logic [DATA_W-1:0] exp_c, nxt_din_c;
    elem_t             nxt_elem_c;
    logic              nxt_op_c, nxt_rd_c;

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load_c),
        .load_up (gen_load_up_c),
        .step    (gen_step_c),
        .limit   (lim),
        .addr    (sram_addr),
        .term_c  (term_c)
    );

    // Access bookkeeping: compare point, end of access, and next op.
    always_comb begin
        rd_c          = op_is_read(elem, op);
        last_c        = op_is_last(elem, op);
        exp_c         = op_data_one(elem, op) ? ~PATTERN : PATTERN;
        cmp_c         = (state == ST_RUN) && (phase == PH_WAIT) && (wait_cnt == WAIT_LAST);
        acc_end_c     = cmp_c || ((state == ST_RUN) && (phase == PH_PULSE) && !rd_c);
        mis_c         = cmp_c && (sram_dout != exp_c);
`ifdef BIST_ERR_COUNT_EN
        stop_c        = 1'b0;
`else
        stop_c        = mis_c;
`endif
        fin_c         = acc_end_c && (stop_c || (last_c && term_c && (elem == EL_M3)));
        start_c       = (state == ST_IDLE) && start && !abort;
        gen_load_c    = start_c || (acc_end_c && !stop_c && last_c && term_c && (elem != EL_M3));
        gen_load_up_c = (state == ST_IDLE) || (elem != EL_M1);
        gen_step_c    = acc_end_c && !stop_c && last_c && !term_c;
        nxt_elem_c    = elem;
        nxt_op_c      = 1'b1;
        if (last_c) begin
            nxt_op_c = 1'b0;
            if (term_c) begin
                nxt_elem_c = elem_t'(elem + 2'd1);
            end
        end
        nxt_rd_c      = op_is_read(nxt_elem_c, nxt_op_c);
        nxt_din_c     = op_data_one(nxt_elem_c, nxt_op_c) ? ~PATTERN : PATTERN;
    end

    // Top FSM, access phases and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            elem       <= EL_M0;
            phase      <= PH_SETUP;
            op         <= 1'b0;
            wait_cnt   <= '0;
            mism       <= 1'b0;
            lim        <= '0;
            sram_sel   <= '0;
            sram_clk   <= 1'b0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_din   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_elem  <= '0;
`ifdef BIST_ERR_COUNT_EN
            err_count  <= '0;
`endif
        end else if ((state != ST_IDLE) && abort) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            sram_clk   <= 1'b0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_c) begin
                        state      <= ST_RUN;
                        elem       <= EL_M0;
                        op         <= 1'b0;
                        phase      <= PH_SETUP;
                        wait_cnt   <= '0;
                        mism       <= 1'b0;
                        lim        <= last_addr;
                        sram_sel   <= sram_sel_in;
                        sram_csb   <= 1'b0;
                        sram_web   <= 1'b0;
                        sram_wmask <= {MASK_W{1'b1}};
                        sram_din   <= PATTERN;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        fail_elem  <= '0;
`ifdef BIST_ERR_COUNT_EN
                        err_count  <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    case (phase)
                        PH_SETUP: begin
                            phase    <= PH_PULSE;
                            sram_clk <= 1'b1;
                        end
                        PH_PULSE: begin
                            sram_clk <= 1'b0;
                            if (rd_c) begin
                                phase    <= PH_WAIT;
                                wait_cnt <= '0;
                            end
                        end
                        PH_WAIT:  wait_cnt <= wait_cnt + 2'd1;
                        default:  phase    <= PH_SETUP;
                    endcase
                    if (mis_c) begin
                        if (!mism) begin
                            mism      <= 1'b1;
                            fail_addr <= sram_addr;
                            fail_data <= sram_dout;
                            fail_elem <= 2'(elem);
                        end
`ifdef BIST_ERR_COUNT_EN
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count <= err_count + ERR_W'(1);
                        end
`endif
                    end
                    if (acc_end_c) begin
                        phase <= PH_SETUP;
                        if (fin_c) begin
                            state      <= ST_FIN;
                            done       <= 1'b1;
                            pass       <= !(mism || mis_c);
                            sram_csb   <= 1'b1;
                            sram_web   <= 1'b1;
                            sram_wmask <= '0;
                        end else begin
                            elem       <= nxt_elem_c;
                            op         <= nxt_op_c;
                            sram_csb   <= 1'b0;
                            sram_web   <= nxt_rd_c;
                            sram_wmask <= nxt_rd_c ? '0 : {MASK_W{1'b1}};
                            sram_din   <= nxt_din_c;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_openram_bist_sequencer.sv
// Scoreboard bench for openram_bist_sequencer: two DUTs (READ_LAT 1 and 3)
// each with a behavioural SRAM that can hold one stuck-at bit. A march
// reference model pushes the expected access stream and run result per
// start; a monitor pops and compares on every SRAM pulse and done pulse.
module tb_openram_bist_sequencer;
    import openram_bist_pkg::*;

    localparam int unsigned AW   = 8;
    localparam int unsigned NDUT = 2;
    localparam logic [31:0] PAT  = 32'h5555_AAAA;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [2:0]    sel;
    } acc_t;

    typedef struct {
        int            cycles;
        logic          pass;
        logic [AW-1:0] faddr;
        logic [31:0]   fdata;
        logic [1:0]    felem;
        int            errs;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset     [NDUT];
    logic          start     [NDUT];
    logic          abort     [NDUT];
    logic [2:0]    sel_in    [NDUT];
    logic [AW-1:0] last_addr [NDUT];
    logic [2:0]    sram_sel  [NDUT];
    logic          sram_clk  [NDUT];
    logic          sram_csb  [NDUT];
    logic          sram_web  [NDUT];
    logic [3:0]    sram_wmask[NDUT];
    logic [AW-1:0] sram_addr [NDUT];
    logic [31:0]   sram_din  [NDUT];
    wire  [31:0]   sram_dout [NDUT];
    logic          busy      [NDUT];
    logic          done      [NDUT];
    logic          pass      [NDUT];
    logic [AW-1:0] fail_addr [NDUT];
    logic [31:0]   fail_data [NDUT];
    logic [1:0]    fail_elem [NDUT];
`ifdef BIST_ERR_COUNT_EN
    logic [15:0]   err_count [NDUT];
`endif

    logic flt_en  [NDUT];
    int   flt_addr[NDUT];
    int   flt_bit [NDUT];
    logic flt_val [NDUT];

    acc_t acc_q[NDUT][$];
    res_t res_q[NDUT][$];
    int   bcnt [NDUT];
    int   n_cmp = 0;
    int   n_bad = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0]   mem [256];
        logic [AW-1:0] rd_a;
        logic [31:0]   dout_m;

        openram_bist_sequencer #(.ADDR_W(AW), .READ_LAT(LAT), .PATTERN(PAT)) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .start      (start[g]),
            .abort      (abort[g]),
            .sram_sel_in(sel_in[g]),
            .last_addr  (last_addr[g]),
            .sram_sel   (sram_sel[g]),
            .sram_clk   (sram_clk[g]),
            .sram_csb   (sram_csb[g]),
            .sram_web   (sram_web[g]),
            .sram_wmask (sram_wmask[g]),
            .sram_addr  (sram_addr[g]),
            .sram_din   (sram_din[g]),
            .sram_dout  (sram_dout[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .fail_addr  (fail_addr[g]),
            .fail_data  (fail_data[g]),
`ifdef BIST_ERR_COUNT_EN
            .err_count  (err_count[g]),
`endif
            .fail_elem  (fail_elem[g])
        );

        // SRAM macro model: acts on the rising edge of its own clock pin.
        always @(posedge sram_clk[g]) begin
            if (!sram_csb[g]) begin
                if (!sram_web[g]) mem[sram_addr[g]] <= sram_din[g];
                else              rd_a <= sram_addr[g];
            end
        end

        always_comb begin
            dout_m = mem[rd_a];
            if (flt_en[g] && (int'(rd_a) == flt_addr[g])) dout_m[flt_bit[g]] = flt_val[g];
        end

        assign sram_dout[g] = dout_m;
    end

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic void chk(string name, int g, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", name, g, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // March C- reference: walks elements/words/ops over an array memory.
    task automatic build(input int g, input int la, input int sel, input bit want_res);
        logic [31:0] m [256];
        res_t r;
        acc_t a;
        int   cyc  = 0;
        int   errs = 0;
        bit   stop = 0;
        r = '{cycles: 0, pass: 1'b1, faddr: '0, fdata: '0, felem: '0, errs: 0};
        for (int e = 0; e < 4 && !stop; e++) begin
            for (int k = 0; k <= la && !stop; k++) begin
                int adr  = (e == 2) ? la - k : k;
                int nops = (e == 1 || e == 2) ? 2 : 1;
                for (int o = 0; o < nops && !stop; o++) begin
                    bit rd  = (e != 0) && (o == 0);
                    bit one = (e == 1 && o == 1) || (e == 2 && o == 0);
                    logic [31:0] word = one ? ~PAT : PAT;
                    logic [31:0] obs;
                    a.we   = !rd;
                    a.addr = AW'(adr);
                    a.data = rd ? 32'h0 : word;
                    a.sel  = 3'(sel);
                    acc_q[g].push_back(a);
                    if (!rd) begin
                        m[adr] = word;
                        cyc += 2;
                    end else begin
                        cyc += 2 + lat_of(g);
                        obs = m[adr];
                        if (flt_en[g] && adr == flt_addr[g]) obs[flt_bit[g]] = flt_val[g];
                        if (obs != word) begin
                            errs++;
                            if (r.pass) begin
                                r.pass  = 1'b0;
                                r.faddr = AW'(adr);
                                r.fdata = obs;
                                r.felem = 2'(e);
                            end
`ifndef BIST_ERR_COUNT_EN
                            stop = 1;
`endif
                        end
                    end
                end
            end
        end
        r.cycles = cyc;
        r.errs   = errs;
        if (want_res) res_q[g].push_back(r);
    endtask

    // One run; ev_cyc >= 0 injects a start pulse (or abort) at that busy cycle.
    task automatic run(input int g, input int la, input int sel, input int ev_cyc, input bit ev_abort);
        int c = 0;
        build(g, la, sel, !ev_abort);
        last_addr[g] = AW'(la);
        sel_in[g]    = 3'(sel);
        start[g]     = 1'b1;
        tick();
        start[g]     = 1'b0;
        while (busy[g] === 1'b1 && c < 4000) begin
            if (c == ev_cyc) begin
                if (ev_abort) abort[g] = 1'b1;
                else          start[g] = 1'b1;
            end
            tick();
            abort[g] = 1'b0;
            start[g] = 1'b0;
            c++;
        end
        if (c >= 4000) chk("run_timeout", g, 64'(c), 64'(0));
        if (ev_abort) begin
            acc_q[g].delete();
            chk("abort_busy", g, 64'(busy[g]), 64'(0));
            chk("abort_pass", g, 64'(pass[g]), 64'(0));
            chk("abort_done", g, 64'(done[g]), 64'(0));
        end
        tick();
    endtask

    task automatic chk_reset_vals(input int g);
        chk("rst_csb",   g, 64'(sram_csb[g]), 64'(1));
        chk("rst_web",   g, 64'(sram_web[g]), 64'(1));
        chk("rst_clk",   g, 64'(sram_clk[g]), 64'(0));
        chk("rst_pins",  g, {sram_wmask[g], sram_addr[g], sram_din[g], sram_sel[g]}, 64'(0));
        chk("rst_stat",  g, {busy[g], done[g], pass[g]}, 64'(0));
        chk("rst_fail",  g, {fail_addr[g], fail_data[g], fail_elem[g]}, 64'(0));
`ifdef BIST_ERR_COUNT_EN
        chk("rst_err",   g, 64'(err_count[g]), 64'(0));
`endif
    endtask

    // Monitor: compares every SRAM pulse and every done pulse against the queues.
    initial begin
        acc_t ea;
        res_t er;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (busy[g] && sram_clk[g] && !sram_csb[g]) begin
                    if (acc_q[g].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL access[dut%0d]: unexpected access at addr %0d", g, sram_addr[g]);
                    end else begin
                        ea = acc_q[g].pop_front();
                        chk("access", g,
                            {!sram_web[g], sram_addr[g], sram_sel[g], sram_wmask[g],
                             sram_web[g] ? 32'h0 : sram_din[g]},
                            {ea.we, ea.addr, ea.sel, ea.we ? 4'hF : 4'h0, ea.data});
                    end
                end
                if (busy[g] && !done[g]) bcnt[g]++;
                if (done[g]) begin
                    if (res_q[g].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL done[dut%0d]: unexpected done pulse", g);
                    end else begin
                        er = res_q[g].pop_front();
                        chk("busy_cycles", g, 64'(bcnt[g]), 64'(er.cycles));
                        chk("pass",        g, 64'(pass[g]), 64'(er.pass));
                        chk("fail_fields", g, {fail_addr[g], fail_data[g], fail_elem[g]},
                            {er.faddr, er.fdata, er.felem});
                        chk("acc_left",    g, 64'(acc_q[g].size()), 64'(0));
`ifdef BIST_ERR_COUNT_EN
                        chk("err_count",   g, 64'(err_count[g]), 64'(er.errs));
`endif
                    end
                end
                if (!busy[g]) bcnt[g] = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            reset[g] = 1'b1; start[g] = 1'b0; abort[g] = 1'b0;
            sel_in[g] = '0; last_addr[g] = '0; bcnt[g] = 0;
            flt_en[g] = 1'b0; flt_addr[g] = 0; flt_bit[g] = 0; flt_val[g] = 1'b0;
        end
        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) reset[g] = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g++) chk_reset_vals(g);

        // Clean run, N=4, L=1.
        run(0, 3, int'(SRAM3), -1, 0);

        // Stuck-at-1 on bit 0 of address 2.
        flt_en[0] = 1'b1; flt_addr[0] = 2; flt_bit[0] = 0; flt_val[0] = 1'b1;
        run(0, 3, int'(SRAM4), -1, 0);
        flt_en[0] = 1'b0;

        // Reset at busy cycle 10, then a clean rerun.
        build(0, 3, int'(SRAM1), 1'b0);
        last_addr[0] = AW'(3); sel_in[0] = SRAM1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (9) tick();
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        acc_q[0].delete();
        chk("midrst_csb",  0, 64'(sram_csb[0]), 64'(1));
        chk("midrst_web",  0, 64'(sram_web[0]), 64'(1));
        chk("midrst_clk",  0, 64'(sram_clk[0]), 64'(0));
        chk("midrst_busy", 0, 64'(busy[0]),     64'(0));
        chk("midrst_pass", 0, 64'(pass[0]),     64'(0));
        run(0, 3, int'(SRAM1), -1, 0);

        // start together with abort in IDLE: stays idle.
        start[0] = 1'b1; abort[0] = 1'b1;
        tick();
        start[0] = 1'b0; abort[0] = 1'b0;
        chk("idle_abort_busy", 0, 64'(busy[0]), 64'(0));
        tick();
        chk("idle_abort_busy2", 0, 64'(busy[0]), 64'(0));

        // start pulsed mid-run is ignored; abort in M2 ends without done.
        run(0, 3, int'(SRAM2), 20, 0);
        run(0, 3, int'(SRAM2), 35, 1);
        run(0, 3, int'(SRAM0), -1, 0);

        // Single-word test on the READ_LAT=3 instance.
        run(1, 0, int'(SRAM5), -1, 0);

        // Randomized runs with random size, macro and optional stuck-at bit.
        for (int i = 0; i < 10; i++) begin
            int g  = i % 2;
            int la = int'($urandom_range(0, 12));
            flt_en[g]   = 1'($urandom_range(0, 1));
            flt_addr[g] = int'($urandom_range(0, la));
            flt_bit[g]  = int'($urandom_range(0, 31));
            flt_val[g]  = 1'($urandom_range(0, 1));
            run(g, la, int'($urandom_range(0, 5)), -1, 0);
        end

        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) begin
            chk("res_left", g, 64'(res_q[g].size()), 64'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
